shift_reg_delay_monitor: RTL and testbench
==========================================

Name: shift_reg_delay_monitor

Overview:
Observes the input and output of a RAM-based delay line (shift register) and measures the actual delay in clock cycles. It checks the measured delay against an expected value, then continuously tracks the output against a history of the input and counts mismatches. It sits beside the delay line as its consumer-side checker, used in on-chip self-test and in benches.

Parameters:
DSIZE, 8, data width of the observed streams.
MAX_DELAY, 16, largest measurable delay in cycles (>=1); also the depth of the history buffer.
CW, $clog2(MAX_DELAY+1), width of the delay fields.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
Din  input  DSIZE  data entering the delay line, sampled every edge.
Dout  input  DSIZE  data leaving the delay line, sampled every edge.
start  input  1  one-cycle request to measure (or re-measure).
exp_delay  input  CW  expected delay; compared once at done.
busy  output  1  high in MEASURE.
done  output  1  one-cycle pulse when a measurement ends (match or timeout).
timeout  output  1  high if the last measurement found no match.
delay_meas  output  CW  measured delay; 0 after timeout.
delay_ok  output  1  delay_meas == exp_delay, latched at done.
locked  output  1  high in TRACK while the last compare matched.
err_cnt  output  16  mismatch count in TRACK; saturates at 16'hFFFF.

Behaviour:
- Reset (async): state IDLE. All outputs 0. History and counter cleared.
- Delay definition: delay D means Dout at edge t equals Din at edge t-D.
- History: on every edge, hist[0] <= Din and hist[i] <= hist[i-1] for i = 1..MAX_DELAY-1. hist[i] therefore holds Din from edge t-1-i. The history runs in all states.
- States:
  - IDLE.
  - MEASURE (busy=1).
  - TRACK.
  - HALT (exists only with the optional feature).
- Transition from IDLE, TRACK or HALT on start=1 at edge t0:
  - marker <= Din(t0); cnt <= 1; err_cnt <= 0; locked <= 0; timeout <= 0; go to MEASURE.
- MEASURE, at each edge:
  - If Dout == marker: delay_meas <= cnt; delay_ok <= (cnt == exp_delay); done pulse; go to TRACK.
  - Else if cnt == MAX_DELAY: timeout <= 1; delay_meas <= 0; delay_ok <= 0; done pulse; go to IDLE.
  - Else cnt <= cnt+1.
  - The first match wins. Streams whose values repeat within MAX_DELAY can produce a shorter delay; this is user responsibility.
  - start is ignored while busy.
- MEASURE timing: the first compare happens at edge t0+1, so the minimum delay is 1. With delay D the done pulse is registered at edge t0+D and is visible after it.
- TRACK, at each edge, compare Dout with hist[delay_meas-1]:
  - Match: locked <= 1.
  - Mismatch: locked <= 0; err_cnt <= err_cnt+1, saturating.
  - The first compare occurs on the edge after entry to TRACK.
- Mid-operation: start in TRACK re-arms a measurement and clears err_cnt. Reset at any time returns everything to reset values immediately.
- start and a mismatch on the same edge: start takes priority; err_cnt clears.
- Arithmetic: cnt is CW bits and cannot overflow because it is bounded by MAX_DELAY. The compare is full DSIZE-bit equality.

Optional Feature:
Macro DELAY_MON_STICKY_ERR_EN.
- Defined: the first mismatch in TRACK increments err_cnt to 1, clears locked, and enters HALT. HALT freezes err_cnt, delay_meas and delay_ok, and holds locked=0. Only start or Reset leaves HALT.
- Undefined: HALT does not exist. TRACK continues after a mismatch, counting every mismatching cycle and re-asserting locked on the next match.

Test Plan:
1. Delay line with tap 5, Din an 8-bit counter, exp_delay=5; pulse start -> done 5 edges later, delay_meas=5, delay_ok=1, timeout=0; locked=1 from the next edge; err_cnt stays 0 for 1000 cycles.
2. Same as 1 with exp_delay=4 -> delay_meas=5, delay_ok=0, TRACK still locks, err_cnt=0.
3. In TRACK, switch the delay-line tap from 5 to 15 -> locked=0 and err_cnt increments every cycle (macro undefined); re-pulse start -> delay_meas=15, err_cnt=0, locked=1.
4. Dout held at 0 with a nonzero marker, MAX_DELAY=16 -> after 16 compare edges: done, timeout=1, delay_meas=0, state IDLE.
5. Assert Reset 3 cycles into MEASURE -> all outputs 0 asynchronously; no done; a fresh start then measures correctly.
6. DELAY_MON_STICKY_ERR_EN defined, inject one corrupted Dout sample in TRACK -> err_cnt=1, locked=0, stays frozen 100 cycles; start -> re-measures and locks.

Source files
------------

// File: rtl/shift_reg_delay_monitor_if.sv
// Bundle of the observed delay-line streams and the monitor's result signals.
// master: the environment driving Din/Dout/start/exp_delay and reading results.
// slave : the monitor itself.
//   Din, Dout   - data entering / leaving the observed delay line
//   start       - one-cycle measurement request
//   exp_delay   - expected delay, compared at done
//   busy, done, timeout, delay_meas, delay_ok, locked, err_cnt - monitor results
interface shift_reg_delay_monitor_if #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned MAX_DELAY = 16,
    parameter int unsigned CW        = $clog2(MAX_DELAY + 1)
);
    logic [DSIZE-1:0] Din;
    logic [DSIZE-1:0] Dout;
    logic             start;
    logic [CW-1:0]    exp_delay;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CW-1:0]    delay_meas;
    logic             delay_ok;
    logic             locked;
    logic [15:0]      err_cnt;

    modport master (
        output Din, Dout, start, exp_delay,
        input  busy, done, timeout, delay_meas, delay_ok, locked, err_cnt
    );

    modport slave (
        input  Din, Dout, start, exp_delay,
        output busy, done, timeout, delay_meas, delay_ok, locked, err_cnt
    );
endinterface

// File: rtl/shift_reg_delay_monitor.sv
// Delay-line monitor: measures the Din->Dout latency of a delay line, checks it
// against exp_delay, then tracks Dout against an internal history of Din and
// counts mismatching cycles.
// Ports:
//   Clock - rising-edge clock
//   Reset - asynchronous, active-high reset
//   mon   - shift_reg_delay_monitor_if.slave (streams, start, results)
// Optional build macro DELAY_MON_STICKY_ERR_EN: the first mismatch in TRACK
// freezes the results in a HALT state until start or Reset.
module shift_reg_delay_monitor #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned MAX_DELAY = 16,
    parameter int unsigned CW        = $clog2(MAX_DELAY + 1)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    shift_reg_delay_monitor_if.slave mon
);

    localparam int unsigned HW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

`ifdef DELAY_MON_STICKY_ERR_EN
    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_TRACK, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_TRACK} state_t;
`endif

    state_t           state_q, state_d;
    logic [DSIZE-1:0] marker_q, marker_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CW-1:0]    delay_meas_q, delay_meas_d;
    logic             delay_ok_q, delay_ok_d;
    logic             locked_q, locked_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [DSIZE-1:0] hist_q [MAX_DELAY];
    logic [HW-1:0]    tap_idx;

    // hist[i] holds Din from i+1 edges ago, so delay D lives at hist[D-1]
    assign tap_idx = HW'(delay_meas_q - CW'(1));

    // History of Din; runs in every state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(MAX_DELAY); i++) hist_q[i] <= '0;
        end else begin
            hist_q[0] <= mon.Din;
            for (int i = 1; i < int'(MAX_DELAY); i++) hist_q[i] <= hist_q[i-1];
        end
    end

    // State and result registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            marker_q     <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            delay_meas_q <= '0;
            delay_ok_q   <= 1'b0;
            locked_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            marker_q     <= marker_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            delay_meas_q <= delay_meas_d;
            delay_ok_q   <= delay_ok_d;
            locked_q     <= locked_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Next-state and result logic; start outside MEASURE has priority
    always_comb begin
        state_d      = state_q;
        marker_d     = marker_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        timeout_d    = timeout_q;
        delay_meas_d = delay_meas_q;
        delay_ok_d   = delay_ok_q;
        locked_d     = locked_q;
        err_cnt_d    = err_cnt_q;

        if (mon.start && (state_q != S_MEASURE)) begin
            marker_d  = mon.Din;
            cnt_d     = CW'(1);
            err_cnt_d = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
            state_d   = S_MEASURE;
        end else begin
            case (state_q)
                S_MEASURE: begin
                    if (mon.Dout == marker_q) begin
                        delay_meas_d = cnt_q;
                        delay_ok_d   = (cnt_q == mon.exp_delay);
                        done_d       = 1'b1;
                        state_d      = S_TRACK;
                    end else if (cnt_q == CW'(MAX_DELAY)) begin
                        timeout_d    = 1'b1;
                        delay_meas_d = '0;
                        delay_ok_d   = 1'b0;
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_TRACK: begin
                    if (mon.Dout == hist_q[tap_idx]) begin
                        locked_d = 1'b1;
                    end else begin
                        locked_d = 1'b0;
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`ifdef DELAY_MON_STICKY_ERR_EN
                        state_d = S_HALT;
`endif
                    end
                end
`ifdef DELAY_MON_STICKY_ERR_EN
                S_HALT: locked_d = 1'b0;
`endif
                default: ;
            endcase
        end

        busy_d = (state_d == S_MEASURE);
    end

    assign mon.busy       = busy_q;
    assign mon.done       = done_q;
    assign mon.timeout    = timeout_q;
    assign mon.delay_meas = delay_meas_q;
    assign mon.delay_ok   = delay_ok_q;
    assign mon.locked     = locked_q;
    assign mon.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_shift_reg_delay_monitor.sv
// Bench for shift_reg_delay_monitor: a modelled delay line with a selectable
// tap feeds the monitor; table-driven measurements plus hand-written sequences.
module tb_shift_reg_delay_monitor;

    localparam int unsigned DSIZE     = 8;
    localparam int unsigned MAX_DELAY = 16;
    localparam int unsigned CW        = 5;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    shift_reg_delay_monitor_if #(.DSIZE(DSIZE), .MAX_DELAY(MAX_DELAY), .CW(CW)) bus ();

    shift_reg_delay_monitor #(.DSIZE(DSIZE), .MAX_DELAY(MAX_DELAY), .CW(CW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .mon   (bus)
    );

    int checks = 0;
    int errors = 0;

`ifdef DELAY_MON_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    // Delay line model: line_q[i] holds Din from i+1 edges ago
    logic [4:0]       tap;
    logic [3:0]       tap_sel;
    logic             zero_mode;
    logic [DSIZE-1:0] corrupt;
    logic [DSIZE-1:0] line_q [MAX_DELAY];

    assign tap_sel = 4'(tap - 5'd1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(MAX_DELAY); i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= bus.Din;
            for (int i = 1; i < int'(MAX_DELAY); i++) line_q[i] <= line_q[i-1];
        end
    end

    assign bus.Dout = zero_mode ? 8'h00 : (line_q[tap_sel] ^ corrupt);

    // Din: counter that skips 0, so markers are never 0 and values are unique within 255 cycles
    initial begin
        logic [7:0] din_cnt;
        din_cnt = 8'h01;
        bus.Din = din_cnt;
        forever begin
            @(negedge Clock);
            din_cnt = (din_cnt == 8'hFF) ? 8'h01 : din_cnt + 8'h01;
            bus.Din = din_cnt;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Called at a negedge; returns at the negedge after the start edge
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge Clock);
        bus.start = 1'b0;
    endtask

    // Edges from the start edge until done is seen; -1 if it never comes
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        string      name;
        logic [4:0] tap;
        logic       zero;
        logic [4:0] exp_delay;
        int         lat;
        logic [4:0] meas;
        logic       ok;
        logic       to;
        int         hold;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        logic seen;

        vecs[0] = '{"tap5_exp5",   5'd5,  1'b0, 5'd5,  5,  5'd5,  1'b1, 1'b0, 1000};
        vecs[1] = '{"tap5_exp4",   5'd5,  1'b0, 5'd4,  5,  5'd5,  1'b0, 1'b0, 200};
        vecs[2] = '{"tap15_exp15", 5'd15, 1'b0, 5'd15, 15, 5'd15, 1'b1, 1'b0, 200};
        vecs[3] = '{"tap1_exp1",   5'd1,  1'b0, 5'd1,  1,  5'd1,  1'b1, 1'b0, 50};
        vecs[4] = '{"tap16_exp16", 5'd16, 1'b0, 5'd16, 16, 5'd16, 1'b1, 1'b0, 50};
        vecs[5] = '{"timeout",     5'd5,  1'b1, 5'd3,  16, 5'd0,  1'b0, 1'b1, 20};

        Reset = 1'b0;
        bus.start = 1'b0;
        bus.exp_delay = '0;
        tap = 5'd5;
        zero_mode = 1'b0;
        corrupt = '0;
        #2 Reset = 1'b1;
        #1;
        check("reset_outputs",
              32'({bus.busy, bus.done, bus.timeout, bus.delay_meas, bus.delay_ok, bus.locked, bus.err_cnt}),
              32'd0);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        idle(20);

        // Table-driven measurements
        for (int v = 0; v < 6; v++) begin
            tap = vecs[v].tap;
            zero_mode = vecs[v].zero;
            bus.exp_delay = vecs[v].exp_delay;
            pulse_start();
            check({vecs[v].name, "_busy"}, 32'(bus.busy), 32'd1);
            wait_done(lat);
            check({vecs[v].name, "_latency"}, 32'(lat), 32'(vecs[v].lat));
            check({vecs[v].name, "_meas"}, 32'(bus.delay_meas), 32'(vecs[v].meas));
            check({vecs[v].name, "_ok"}, 32'(bus.delay_ok), 32'(vecs[v].ok));
            check({vecs[v].name, "_timeout"}, 32'(bus.timeout), 32'(vecs[v].to));
            check({vecs[v].name, "_busy_off"}, 32'(bus.busy), 32'd0);
            idle(1);
            check({vecs[v].name, "_lock1"}, 32'(bus.locked), 32'(!vecs[v].to));
            idle(vecs[v].hold - 1);
            check({vecs[v].name, "_err_hold"}, 32'(bus.err_cnt), 32'd0);
            check({vecs[v].name, "_lock_hold"}, 32'(bus.locked), 32'(!vecs[v].to));
        end
        zero_mode = 1'b0;

        // start while busy must not re-arm the measurement
        tap = 5'd5;
        bus.exp_delay = 5'd5;
        pulse_start();
        idle(1);
        pulse_start();
        wait_done(lat);
        check("restart_ignored_latency", 32'(lat), 32'd3);
        check("restart_ignored_meas", 32'(bus.delay_meas), 32'd5);
        idle(5);
        check("restart_ignored_lock", 32'(bus.locked), 32'd1);

        // Tap moves from 5 to 15 while tracking
        tap = 5'd15;
        idle(10);
        check("tap_move_err", 32'(bus.err_cnt), STICKY ? 32'd1 : 32'd10);
        check("tap_move_lock", 32'(bus.locked), 32'd0);
        bus.exp_delay = 5'd15;
        pulse_start();
        check("remeasure_err_clear", 32'(bus.err_cnt), 32'd0);
        check("remeasure_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("remeasure_latency", 32'(lat), 32'd15);
        check("remeasure_meas", 32'(bus.delay_meas), 32'd15);
        check("remeasure_ok", 32'(bus.delay_ok), 32'd1);
        idle(1);
        check("remeasure_lock", 32'(bus.locked), 32'd1);
        idle(20);
        check("remeasure_err_hold", 32'(bus.err_cnt), 32'd0);

        // One corrupted Dout sample while tracking
        corrupt = 8'h5A;
        @(negedge Clock);
        corrupt = '0;
        check("corrupt_err", 32'(bus.err_cnt), 32'd1);
        check("corrupt_lock", 32'(bus.locked), 32'd0);
        idle(1);
        check("corrupt_relock", 32'(bus.locked), STICKY ? 32'd0 : 32'd1);
        idle(100);
        check("corrupt_err_hold", 32'(bus.err_cnt), 32'd1);
        check("corrupt_lock_hold", 32'(bus.locked), STICKY ? 32'd0 : 32'd1);
        check("corrupt_meas_hold", 32'({bus.delay_meas, bus.delay_ok}), 32'({5'd15, 1'b1}));
        pulse_start();
        wait_done(lat);
        check("corrupt_remeasure_latency", 32'(lat), 32'd15);
        check("corrupt_remeasure_meas", 32'(bus.delay_meas), 32'd15);
        idle(1);
        check("corrupt_remeasure_lock", 32'(bus.locked), 32'd1);
        check("corrupt_remeasure_err", 32'(bus.err_cnt), 32'd0);

        // Reset in the middle of a measurement
        tap = 5'd5;
        bus.exp_delay = 5'd5;
        pulse_start();
        idle(2);
        #1 Reset = 1'b1;
        #1;
        check("midreset_outputs",
              32'({bus.busy, bus.done, bus.timeout, bus.delay_meas, bus.delay_ok, bus.locked, bus.err_cnt}),
              32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            if (bus.done) seen = 1'b1;
        end
        check("midreset_no_done", 32'(seen), 32'd0);
        idle(10);
        pulse_start();
        wait_done(lat);
        check("postreset_latency", 32'(lat), 32'd5);
        check("postreset_meas_ok", 32'({bus.delay_meas, bus.delay_ok}), 32'({5'd5, 1'b1}));
        idle(1);
        check("postreset_lock", 32'(bus.locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
